// File: rtl/afe_ro_sram_ctrl_pkg.sv
// afe_ro_pkg: shared types and default sizes for the AFE readout SRAM
// buffer controller.
//   arb_win_e          : which side owns the single SRAM port this cycle
//   AFE_DATA_WIDTH_DEF : default sample width
//   ADDR_WIDTH_DEF     : default SRAM address width (depth = 2**ADDR_WIDTH)
package afe_ro_pkg;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_WR   = 2'd1,
        WIN_RD   = 2'd2
    } arb_win_e;

    localparam int AFE_DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF     = 10;

endpackage

// File: rtl/afe_ro_sram_ctrl_if.sv
// afe_ro_sram_ctrl_if: bus bundle of the AFE readout buffer controller.
//   AFE side   : wr_valid_i / wr_ready_o / wr_data_i   (valid/ready)
//   Readout    : rd_req_i / rd_gnt_o / rd_valid_o / rd_data_o
//   SRAM port  : sram_cen_o / sram_wen_o (active low), sram_addr_o,
//                sram_wdata_o, sram_rdata_i (1-cycle read latency)
// Signal suffixes are from the controller's point of view.
//   slave  : used by the controller
//   master : used by the environment (AFE, readout requester, SRAM)
interface afe_ro_sram_ctrl_if #(
    parameter int AFE_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 10
);
    logic                      wr_valid_i;
    logic                      wr_ready_o;
    logic [AFE_DATA_WIDTH-1:0] wr_data_i;
    logic                      rd_req_i;
    logic                      rd_gnt_o;
    logic                      rd_valid_o;
    logic [AFE_DATA_WIDTH-1:0] rd_data_o;
    logic                      sram_cen_o;
    logic                      sram_wen_o;
    logic [ADDR_WIDTH-1:0]     sram_addr_o;
    logic [AFE_DATA_WIDTH-1:0] sram_wdata_o;
    logic [AFE_DATA_WIDTH-1:0] sram_rdata_i;

    modport slave (
        input  wr_valid_i, wr_data_i, rd_req_i, sram_rdata_i,
        output wr_ready_o, rd_gnt_o, rd_valid_o, rd_data_o,
               sram_cen_o, sram_wen_o, sram_addr_o, sram_wdata_o
    );

    modport master (
        output wr_valid_i, wr_data_i, rd_req_i, sram_rdata_i,
        input  wr_ready_o, rd_gnt_o, rd_valid_o, rd_data_o,
               sram_cen_o, sram_wen_o, sram_addr_o, sram_wdata_o
    );
endinterface

// File: rtl/afe_ro_sram_ctrl_arb.sv
// afe_ro_rr_arb2: two-requester round-robin arbiter (write side vs read
// side) with a last-winner register.
//   clk_i, rst_ni : clock, synchronous active-low reset (last winner -> RD)
//   req_wr_i      : write side eligible
//   req_rd_i      : read side eligible
//   gnt_o         : one-hot grant, [0] = write, [1] = read
module afe_ro_rr_arb2
    import afe_ro_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_wr_i,
    input  logic       req_rd_i,
    output logic [1:0] gnt_o
);

    arb_win_e last_win_q, last_win_d;
    arb_win_e win;

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) last_win_q <= WIN_RD;
        else         last_win_q <= last_win_d;
    end

    // next state: remember whoever was granted
    always_comb begin
        last_win_d = last_win_q;
        if (win != WIN_NONE) last_win_d = win;
    end

    // output: on contention the side that did not win last time gets it
    always_comb begin
        win = WIN_NONE;
        if (req_wr_i && req_rd_i) win = (last_win_q == WIN_WR) ? WIN_RD : WIN_WR;
        else if (req_wr_i)        win = WIN_WR;
        else if (req_rd_i)        win = WIN_RD;
        gnt_o = {win == WIN_RD, win == WIN_WR};
    end

endmodule

// File: rtl/afe_ro_sram_ctrl.sv
// afe_ro_sram_ctrl: circular-buffer controller in front of a single-port
// AFE readout SRAM. AFE samples land in a 1-entry holding register and are
// written to the SRAM when the write side wins the port; readout pops are
// served by issuing SRAM reads, data comes back one cycle after rd_gnt_o.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : synchronous buffer clear
//   bus           : AFE / readout / SRAM signals (afe_ro_sram_ctrl_if.slave)
//   fill_o        : number of stored entries (0..depth)
//   overflow_o    : sticky overflow flag
// Build option: define AFE_RO_OVERWRITE_EN to overwrite the oldest entry
// when full instead of stalling the AFE.
module afe_ro_sram_ctrl
    import afe_ro_pkg::*;
#(
    parameter int AFE_DATA_WIDTH = AFE_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    afe_ro_sram_ctrl_if.slave   bus,
    output logic [ADDR_WIDTH:0] fill_o,
    output logic                overflow_o
);

`ifdef AFE_RO_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]       fill_q, fill_d;
    logic                      hold_valid_q, hold_valid_d;
    logic [AFE_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                      ovf_q, ovf_d;
    logic                      rd_valid_q;

    logic       full, wr_elig, rd_elig, wr_win, rd_win, wr_hs;
    logic [1:0] gnt;

    assign full    = (fill_q == FULL_CNT);
    assign wr_elig = hold_valid_q && (OVW || !full);
    assign rd_elig = bus.rd_req_i && (fill_q != '0);

    afe_ro_rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_wr_i (wr_elig),
        .req_rd_i (rd_elig),
        .gnt_o    (gnt)
    );

    assign wr_win = gnt[0];
    assign rd_win = gnt[1];

    // The holding register frees up in the same cycle its content is written.
    assign bus.wr_ready_o = !hold_valid_q || wr_win;
    assign wr_hs          = bus.wr_valid_i && bus.wr_ready_o;

    // SRAM port is driven straight from the arbitration result.
    always_comb begin
        bus.sram_cen_o   = 1'b1;
        bus.sram_wen_o   = 1'b1;
        bus.sram_addr_o  = '0;
        bus.sram_wdata_o = '0;
        if (wr_win) begin
            bus.sram_cen_o   = 1'b0;
            bus.sram_wen_o   = 1'b0;
            bus.sram_addr_o  = wr_ptr_q;
            bus.sram_wdata_o = hold_data_q;
        end else if (rd_win) begin
            bus.sram_cen_o  = 1'b0;
            bus.sram_addr_o = rd_ptr_q;
        end
    end

    assign bus.rd_gnt_o   = rd_win;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = bus.sram_rdata_i;
    assign fill_o         = fill_q;
    assign overflow_o     = ovf_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        ovf_d        = ovf_q;

        if (wr_win) wr_ptr_d = wr_ptr_q + 1'b1;
        // a write into a full buffer (overwrite build) drops the oldest entry
        if (rd_win || (OVW && wr_win && full)) rd_ptr_d = rd_ptr_q + 1'b1;

        if (wr_win && !full)  fill_d = fill_q + 1'b1;
        else if (rd_win)      fill_d = fill_q - 1'b1;

        if (wr_hs) begin
            hold_valid_d = 1'b1;
            hold_data_d  = bus.wr_data_i;
        end else if (wr_win) begin
            hold_valid_d = 1'b0;
        end

        // stall build: the AFE pushing against a full buffer is the overflow
        if (OVW) begin
            if (wr_win && full) ovf_d = 1'b1;
        end else begin
            if (bus.wr_valid_i && full && hold_valid_q) ovf_d = 1'b1;
        end

        if (clr_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fill_d       = '0;
            hold_valid_d = 1'b0;
            ovf_d        = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            ovf_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            ovf_q        <= ovf_d;
            // a clear drops the read issued alongside it
            rd_valid_q   <= rd_win && !clr_i;
        end
    end

endmodule

// File: tb/tb_afe_ro_sram_ctrl.sv
module tb_afe_ro_sram_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clr_i = 1'b0;
    logic [AW:0]   fill_o;
    logic          overflow_o;

    afe_ro_sram_ctrl_if #(.AFE_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    afe_ro_sram_ctrl #(.AFE_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .bus        (bus),
        .fill_o     (fill_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // behavioural single-port SRAM, 1-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sram_rdata = '0;
    assign bus.sram_rdata_i = sram_rdata;
    always @(posedge clk_i) begin
        if (bus.sram_cen_o == 1'b0) begin
            if (bus.sram_wen_o == 1'b0) mem[bus.sram_addr_o] <= bus.sram_wdata_o;
            else                        sram_rdata <= mem[bus.sram_addr_o];
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: buffer content as a FIFO queue of samples, plus the
    // holding register, the fairness memory and the pending read result.
    int unsigned m_q[$];
    bit          m_known   = 0;
    int          m_wp      = 0;
    int          m_rp      = 0;
    bit          m_hv      = 0;
    int unsigned m_hd      = 0;
    bit          m_last_rd = 1;
    bit          m_ovf     = 0;
    bit          m_rv      = 0;
    int unsigned m_rd      = 0;
    int          m_wr_cnt  = 0;

    task automatic step(input bit rst, input bit clr, input bit wv,
                        input logic [DW-1:0] wd, input bit rr);
        bit we, re, gw, gr, full, hs;
        int fill;
        rst_ni         = !rst;
        clr_i          = clr;
        bus.wr_valid_i = wv;
        bus.wr_data_i  = wd;
        bus.rd_req_i   = rr;
        #2;
        fill = m_q.size();
        full = (fill == DEPTH);
`ifdef AFE_RO_OVERWRITE_EN
        we = m_hv;
`else
        we = m_hv && !full;
`endif
        re = rr && (fill != 0);
        gw = we && (!re || m_last_rd);
        gr = re && (!we || !m_last_rd);
        if (m_known) begin
            chk("wr_ready", bus.wr_ready_o, !m_hv || gw);
            chk("rd_gnt",   bus.rd_gnt_o, gr);
            chk("cen",      bus.sram_cen_o, !(gw || gr));
            chk("wen",      bus.sram_wen_o, !gw);
            chk("addr",     bus.sram_addr_o, gw ? m_wp : (gr ? m_rp : 0));
            if (gw) chk("wdata", bus.sram_wdata_o, m_hd);
            chk("fill",     fill_o, fill);
            chk("overflow", overflow_o, m_ovf);
            chk("rd_valid", bus.rd_valid_o, m_rv);
            if (m_rv) chk("rd_data", bus.rd_data_o, m_rd);
        end
        @(posedge clk_i);
        if (rst) begin
            m_q.delete();
            m_wp = 0; m_rp = 0; m_hv = 0; m_hd = 0;
            m_last_rd = 1; m_ovf = 0; m_rv = 0; m_known = 1;
        end else if (m_known) begin
            m_rv = gr && !clr;
            if (gr) m_rd = m_q[0];
`ifdef AFE_RO_OVERWRITE_EN
            if (gw && full) m_ovf = 1;
`else
            if (wv && full && m_hv) m_ovf = 1;
`endif
            if (gw) begin
                if (full) begin
                    void'(m_q.pop_front());
                    m_rp = (m_rp + 1) % DEPTH;
                end
                m_q.push_back(m_hd);
                m_wp = (m_wp + 1) % DEPTH;
                m_wr_cnt++;
            end
            if (gr) begin
                void'(m_q.pop_front());
                m_rp = (m_rp + 1) % DEPTH;
            end
            hs = wv && (!m_hv || gw);
            if (hs) begin
                m_hv = 1; m_hd = wd;
            end else if (gw) begin
                m_hv = 0;
            end
            if (gw || gr) m_last_rd = gr;
            if (clr) begin
                m_q.delete();
                m_wp = 0; m_rp = 0; m_hv = 0; m_ovf = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, rr);
    endtask

    initial begin
        int guard;
        bus.wr_valid_i = 0;
        bus.wr_data_i  = 0;
        bus.rd_req_i   = 0;

        // reset, then idle with a pop request on an empty buffer
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_fill", fill_o, 0);
        chk("rst_cen",  bus.sram_cen_o, 1);
        chk("rst_rvld", bus.rd_valid_o, 0);
        idle(3, 1);

        // four samples in, four pops out
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'hA0 + i, 0);
        idle(2, 0);
        chk("fill4", fill_o, 4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        idle(2, 0);
        chk("fill0", fill_o, 0);

        // continuous push and pop around fill=2: grants alternate
        guard = 0;
        while ((m_q.size() < 2 || m_hv) && guard < 20) begin
            step(0, 0, m_q.size() + (m_hv ? 1 : 0) < 2, $urandom, 0);
            guard++;
        end
        chk("alt_fill", fill_o, 2);
        for (int i = 0; i < 20; i++) step(0, 0, 1, $urandom, 1);
        idle(1, 0);
        while (m_q.size() != 0 && guard < 60) begin step(0, 0, 0, 0, 1); guard++; end

        // wrap-around: 1500 writes with pops keeping the buffer shallow
        m_wr_cnt = 0;
        guard = 0;
        while (m_wr_cnt < 1500 && guard < 8000) begin
            step(0, 0, ($urandom % 4) != 0, $urandom,
                 (m_q.size() >= 6) || ($urandom % 2 == 1));
            guard++;
        end
        chk("wrap_writes", (m_wr_cnt >= 1500), 1);
        chk("wrap_ovf", overflow_o, 0);

        // clear right after a read grant with fill=5
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h500 + i, 0);
        idle(2, 0);
        chk("clr_fill5", fill_o, 5);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        chk("clr_rvld", bus.rd_valid_o, 0);
        chk("clr_fill", fill_o, 0);
        step(0, 0, 1, 32'h77, 0);
        step(0, 0, 0, 0, 0);

        // fill to the top and keep pushing
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH + 6; i++) step(0, 0, 1, i, 0);
        chk("full_fill", fill_o, DEPTH);
        chk("full_ovf",  overflow_o, 1);
`ifndef AFE_RO_OVERWRITE_EN
        chk("full_rdy",  bus.wr_ready_o, 0);
`endif
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        guard = 0;
        while (m_q.size() != 0 && guard < 2 * DEPTH) begin step(0, 0, 0, 0, 1); guard++; end
        idle(2, 0);

        // randomized traffic with occasional clear and reset
        for (int i = 0; i < 1500; i++)
            step(($urandom % 200) == 0, ($urandom % 100) == 0,
                 $urandom % 2, $urandom, $urandom % 2);

        // reset mid-operation discards the in-flight read
        step(0, 0, 1, 32'h99, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("rst_mid_rvld", bus.rd_valid_o, 0);
        idle(2, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
